mc_inject: RTL and testbench

MC_INJECT -- requirements
Module: mc_inject

---
 rtl/mc_inject.sv | 130 +++++++++++++
 tb/tb_mc_inject.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_inject.sv
// Multicast injection front-end: splits a destination bitmap into a local hit
// and a unicast or multicast header flit, queued in order for the router.
module mc_inject #(
    parameter int DST_WIDTH      = 6,
    parameter int DST_LIST_WIDTH = 64,
    parameter int PLD_WIDTH      = 32,
    parameter int TIME_WIDTH     = 8,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DST_WIDTH-1:0]      my_id,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DST_LIST_WIDTH-1:0] req_dstmap,
    input  logic [PLD_WIDTH-1:0]      req_payload,
    output logic                      local_hit,
    output logic                      drop,
    output logic                      inj_valid,
    input  logic                      inj_ready,
    output logic                      inj_mc,
    output logic [DST_WIDTH-1:0]      inj_dst,
    output logic [DST_LIST_WIDTH-1:0] inj_dstList,
    output logic [PLD_WIDTH-1:0]      inj_payload,
    output logic [TIME_WIDTH-1:0]     inj_time
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic                      mc;
        logic [DST_WIDTH-1:0]      dst;
        logic [DST_LIST_WIDTH-1:0] dst_list;
        logic [PLD_WIDTH-1:0]      payload;
        logic [TIME_WIDTH-1:0]     stamp;
    } entry_t;

    entry_t                    mem [DEPTH];
    entry_t                    wr_entry;
    entry_t                    head;
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [TIME_WIDTH-1:0]     tnow;
    logic                      run_q;
    logic                      full;
    logic                      empty;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      hit;
    logic                      none;
    logic                      multi;
    logic [DST_LIST_WIDTH-1:0] self_bit;
    logic [DST_LIST_WIDTH-1:0] map_rem;
    logic [DST_WIDTH-1:0]      low_idx;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // run_q holds req_ready low until the first edge after reset release
    assign req_ready = run_q && !full;
    assign inj_valid = !empty;
    assign accept    = req_valid && req_ready;
    assign pop       = inj_valid && inj_ready;

    assign self_bit = DST_LIST_WIDTH'(1) << my_id;
    assign map_rem  = req_dstmap & ~self_bit;
    assign hit      = |(req_dstmap & self_bit);
    assign none     = (map_rem == '0);
    assign multi    = |(map_rem & (map_rem - DST_LIST_WIDTH'(1)));
    assign push     = accept && !none;

    always_comb begin
        low_idx = '0;
        for (int i = DST_LIST_WIDTH - 1; i >= 0; i--) begin
            if (map_rem[i]) low_idx = DST_WIDTH'(i);
        end
    end

    always_comb begin
        wr_entry          = '0;
        wr_entry.mc       = multi;
        wr_entry.dst      = low_idx;
        wr_entry.dst_list = multi ? map_rem : '0;
        wr_entry.payload  = req_payload;
        wr_entry.stamp    = tnow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tnow      <= '0;
            run_q     <= 1'b0;
            local_hit <= 1'b0;
            drop      <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            tnow      <= tnow + TIME_WIDTH'(1);
            local_hit <= accept && hit;
            drop      <= accept && none;
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    assign head = mem[rd_ptr[AW-1:0]];

    // Fields read zero whenever the queue is empty, including under reset
    always_comb begin
        inj_mc      = 1'b0;
        inj_dst     = '0;
        inj_dstList = '0;
        inj_payload = '0;
        inj_time    = '0;
        if (inj_valid) begin
            inj_mc      = head.mc;
            inj_dst     = head.dst;
            inj_dstList = head.dst_list;
            inj_payload = head.payload;
            inj_time    = head.stamp;
        end
    end

endmodule

// File: tb/tb_mc_inject.sv
// Scoreboard bench for mc_inject: reference model queues expected flits at
// acceptance and compares them as the router side pops.
module tb_mc_inject;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  my_id;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_dstmap;
    logic [31:0] req_payload;
    logic        local_hit;
    logic        drop;
    logic        inj_valid;
    logic        inj_ready;
    logic        inj_mc;
    logic [5:0]  inj_dst;
    logic [63:0] inj_dstList;
    logic [31:0] inj_payload;
    logic [7:0]  inj_time;

    mc_inject dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .my_id       (my_id),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dstmap  (req_dstmap),
        .req_payload (req_payload),
        .local_hit   (local_hit),
        .drop        (drop),
        .inj_valid   (inj_valid),
        .inj_ready   (inj_ready),
        .inj_mc      (inj_mc),
        .inj_dst     (inj_dst),
        .inj_dstList (inj_dstList),
        .inj_payload (inj_payload),
        .inj_time    (inj_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        none;
        logic        mc;
        logic [5:0]  dst;
        logic [63:0] dl;
        logic [31:0] pld;
        logic [7:0]  t;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tb_t;
    logic        run_m;
    logic        pend_hit;
    logic        pend_drop;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] map, input logic [5:0] id,
                                   input logic [31:0] pld, input logic [7:0] t);
        exp_t        e;
        logic [63:0] m;
        int          cnt;
        m   = map & ~(64'd1 << id);
        cnt = 0;
        e.dst = '0;
        for (int i = 0; i < 64; i++) begin
            if (m[i]) begin
                if (cnt == 0) e.dst = 6'(i);
                cnt++;
            end
        end
        e.none = (cnt == 0);
        e.mc   = (cnt >= 2);
        e.dl   = (cnt >= 2) ? m : 64'd0;
        e.pld  = pld;
        e.t    = t;
        return e;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_t  <= '0;
            run_m <= 1'b0;
        end else begin
            tb_t  <= tb_t + 8'd1;
            run_m <= 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            q.delete();
            pend_hit  = 1'b0;
            pend_drop = 1'b0;
        end else begin
            chk("req_ready", req_ready, run_m && (q.size() < 4));
            chk("inj_valid", inj_valid, q.size() != 0);
            chk("local_hit", local_hit, pend_hit);
            chk("drop", drop, pend_drop);
            if (inj_valid && inj_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("sb_mc", inj_mc, e.mc);
                chk("sb_dst", inj_dst, e.dst);
                chk("sb_dstList", inj_dstList, e.dl);
                chk("sb_payload", inj_payload, e.pld);
                chk("sb_time", inj_time, e.t);
            end
            pend_hit  = 1'b0;
            pend_drop = 1'b0;
            if (req_valid && req_ready) begin
                e = model(req_dstmap, my_id, req_payload, tb_t);
                pend_hit  = req_dstmap[my_id];
                pend_drop = e.none;
                if (!e.none) q.push_back(e);
            end
        end
    end

    // Called just after a rising edge; offers one request for one cycle
    task automatic drive(input logic [63:0] map, input logic [31:0] pld);
        req_valid   = 1'b1;
        req_dstmap  = map;
        req_payload = pld;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int guard;
        logic [63:0] m;
        reset_n     = 1'b0;
        my_id       = 6'd5;
        req_valid   = 1'b0;
        req_dstmap  = '0;
        req_payload = '0;
        inj_ready   = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_inj_valid", inj_valid, 0);
        chk("rst_local_hit", local_hit, 0);
        chk("rst_drop", drop, 0);
        chk("rst_inj_dst", inj_dst, 0);
        chk("rst_inj_time", inj_time, 0);
        #21;
        reset_n = 1'b1;
        #1;
        chk("ready_before_edge", req_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", req_ready, 1);

        drive(64'd1 << 9, 32'hA001);
        chk("uc_valid", inj_valid, 1);
        chk("uc_mc", inj_mc, 0);
        chk("uc_dst", inj_dst, 9);
        chk("uc_dstList", inj_dstList, 0);
        idle(1);
        chk("uc_popped", inj_valid, 0);

        drive(64'h224, 32'hB002);
        chk("mc_hit", local_hit, 1);
        chk("mc_mc", inj_mc, 1);
        chk("mc_dstList", inj_dstList, 64'h204);
        chk("mc_dst", inj_dst, 2);

        drive(64'd1 << 5, 32'hC003);
        chk("self_hit", local_hit, 1);
        chk("self_drop", drop, 1);
        chk("self_valid", inj_valid, 0);

        inj_ready = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) drive(64'd1 << (10 + i), 32'hD000 + i);
        chk("full_ready", req_ready, 0);
        drive(64'd1 << 20, 32'hDEAD);
        inj_ready = 1'b1;
        @(posedge clk);
        #1;
        inj_ready = 1'b0;
        chk("one_pop_ready", req_ready, 1);
        chk("one_pop_valid", inj_valid, 1);
        chk("one_pop_head", inj_dst, 11);
        inj_ready = 1'b1;
        idle(6);
        chk("drained", inj_valid, 0);

        for (int i = 0; i < 40; i++) begin
            inj_ready = 1'($urandom_range(0, 1));
            my_id = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: m = 64'd1 << $urandom_range(0, 63);
                1: m = 64'd1 << my_id;
                default: m = {$urandom, $urandom};
            endcase
            drive(m, $urandom);
        end
        inj_ready = 1'b1;
        my_id = 6'd5;
        idle(8);

        inj_ready = 1'b0;
        guard = 0;
        while (tb_t != 8'd254 && guard < 600) begin
            idle(1);
            guard++;
        end
        chk("wrap_reach", tb_t, 254);
        drive(64'd1 << 1, 32'hE000);
        drive(64'd1 << 2, 32'hE001);
        drive(64'd1 << 3, 32'hE002);
        chk("wrap_t0", inj_time, 254);
        inj_ready = 1'b1;
        idle(1);
        inj_ready = 1'b0;
        chk("wrap_t1", inj_time, 255);
        inj_ready = 1'b1;
        idle(1);
        inj_ready = 1'b0;
        chk("wrap_t2", inj_time, 0);
        inj_ready = 1'b1;
        idle(1);
        chk("wrap_empty", inj_valid, 0);

        inj_ready = 1'b0;
        drive(64'h3 << 6, 32'hF000);
        drive(64'd1 << 7, 32'hF001);
        drive(64'd1 << 8, 32'hF002);
        chk("pre_rst_valid", inj_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", inj_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        idle(2);
        reset_n = 1'b1;
        inj_ready = 1'b1;
        idle(4);
        chk("post_rst_valid", inj_valid, 0);
        drive(64'd1 << 30, 32'h1234);
        chk("post_rst_dst", inj_dst, 30);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
